// File: rtl/dpll_rx_pkg.sv
// Shared types and constants for the DPLL receive sampler.
// Optional parity support is selected in the top level by DPLL_RX_PARITY_EN.
package dpll_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    // Bit counter must cover DATA_W+1 strobes when parity is enabled.
    localparam int BIT_CNT_W  = 4;
    localparam int BYTE_CNT_W = 8;
    localparam int TMO_CNT_W  = 8;

endpackage

// File: rtl/dpll_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous active-low reset.
module dpll_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops let a metastable first stage settle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dpll_rx_sampler.sv
// Samples serial data on recovered-clock edges, hunts for the sync word,
// assembles bytes and hands them out on a valid/ready interface.
// Optional build macro: DPLL_RX_PARITY_EN (one even-parity bit after each byte).
module dpll_rx_sampler
    import dpll_rx_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(SYNC_WORD_DEFAULT),
    parameter int                FRAME_LEN = 16,
    parameter int                TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_clk,
    input  logic              syn,
    input  logic              data_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_start,
    output logic              out_perr,
    output logic              in_frame,
    output logic              overflow,
    input  logic              ovf_clr
);

`ifdef DPLL_RX_PARITY_EN
    localparam int BITS_PER_BYTE = DATA_W + 1;
`else
    localparam int BITS_PER_BYTE = DATA_W;
`endif

    localparam logic [BIT_CNT_W-1:0]  BIT_LAST   = BIT_CNT_W'(BITS_PER_BYTE - 1);
    localparam logic [BYTE_CNT_W-1:0] FRAME_LAST = BYTE_CNT_W'(FRAME_LEN - 1);
    localparam logic [TMO_CNT_W-1:0]  TMO_LAST   = TMO_CNT_W'(TIMEOUT);

    logic                  rs2, rs3, ds2, strobe;
    logic [DATA_W-1:0]     shreg, shreg_next, byte_val;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [TMO_CNT_W-1:0]  tmo_cnt;
    logic                  abort, byte_done, can_load, byte_perr;
    state_t                state, state_n;

    dpll_sync2 u_sync_rec (.clk(clk), .reset(reset), .d(rec_clk), .q(rs2));
    dpll_sync2 u_sync_dat (.clk(clk), .reset(reset), .d(data_in), .q(ds2));

    // Extra rec_clk flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!reset) rs3 <= 1'b0;
        else        rs3 <= rs2;
    end

    assign strobe     = rs2 & ~rs3;
    assign shreg_next = {shreg[DATA_W-2:0], ds2};
    assign abort      = ~syn | (tmo_cnt == TMO_LAST);
    assign can_load   = ~out_valid | out_ready;

`ifdef DPLL_RX_PARITY_EN
    // On the parity strobe shreg still holds the data bits; the live bit is parity.
    assign byte_val  = shreg;
    assign byte_perr = ^{shreg, ds2};
`else
    assign byte_val  = shreg_next;
    assign byte_perr = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic and byte-completion detect; abort overrides everything.
    always_comb begin
        state_n   = state;
        byte_done = 1'b0;
        unique case (state)
            IDLE: if (syn) state_n = HUNT;
            HUNT: if (strobe && shreg_next == SYNC_WORD) state_n = DATA;
            DATA: begin
                if (strobe && bit_cnt == BIT_LAST) begin
                    byte_done = 1'b1;
                    if (byte_cnt == FRAME_LAST) state_n = HUNT;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n   = IDLE;
            byte_done = 1'b0;
        end
    end

    // Lock timeout: cleared by any strobe or in IDLE, saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (!reset)                        tmo_cnt <= '0;
        else if (state == IDLE || strobe)  tmo_cnt <= '0;
        else if (tmo_cnt != TMO_LAST)      tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
    end

    // Shift register and bit/byte counters; IDLE clears, HUNT holds counters at zero.
    always_ff @(posedge clk) begin
        if (!reset || state == IDLE) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            if (strobe) shreg <= shreg_next;
            if (state == HUNT) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (strobe) begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt  <= '0;
                    byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                end else begin
                    bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                end
            end
        end
    end

    // Output register with valid/ready handshake and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            out_perr    <= 1'b0;
            overflow    <= 1'b0;
            in_frame    <= 1'b0;
        end else begin
            if (byte_done && can_load) begin
                out_data    <= byte_val;
                out_valid   <= 1'b1;
                frame_start <= (byte_cnt == '0);
                out_perr    <= byte_perr;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (byte_done && !can_load) overflow <= 1'b1;
            else if (ovf_clr)           overflow <= 1'b0;
            in_frame <= (state_n == DATA);
        end
    end

endmodule

// File: tb/tb_dpll_rx_sampler.sv
// Scoreboard bench for dpll_rx_sampler: serial frames driven through rec_clk/data_in,
// expected bytes queued at issue time and compared when the DUT hands them over.
module tb_dpll_rx_sampler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rec_clk = 1'b0;
    logic       syn = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       frame_start;
    logic       out_perr;
    logic       in_frame;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       fs;
        logic       pe;
    } exp_t;

    exp_t sb[$];

    dpll_rx_sampler dut (
        .clk(clk), .reset(reset), .rec_clk(rec_clk), .syn(syn), .data_in(data_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_start(frame_start), .out_perr(out_perr), .in_frame(in_frame),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_perr(input logic [7:0] b, input logic par);
        logic pe;
        pe = ^{b, par};
`ifndef DPLL_RX_PARITY_EN
        pe = 1'b0;
`endif
        return pe;
    endfunction

    // mode 1: check out_valid latency on this bit, mode 2: check in_frame latency.
    task automatic send_bit(input logic b, input int mode);
        data_in = b;
        repeat (8) @(negedge clk);
        rec_clk = 1'b1;
        repeat (2) @(negedge clk);
        if (mode == 1) chk("valid_early", out_valid, 0);
        if (mode == 2) chk("inframe_early", in_frame, 0);
        @(negedge clk);
        if (mode == 1) chk("valid_lat", out_valid, 1);
        if (mode == 2) chk("inframe_lat", in_frame, 1);
        repeat (5) @(negedge clk);
        rec_clk = 1'b0;
    endtask

    task automatic send_sync(input bit latchk);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 7; i >= 0; i--) send_bit(s[i], (i == 0 && latchk) ? 2 : 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par, input logic fs,
                             input bit push, input bit latchk);
        exp_t e;
        if (push) begin
            e.d = b; e.fs = fs; e.pe = exp_perr(b, par);
            sb.push_back(e);
        end
`ifdef DPLL_RX_PARITY_EN
        for (int i = 7; i >= 0; i--) send_bit(b[i], 0);
        send_bit(par, latchk ? 1 : 0);
`else
        for (int i = 7; i >= 0; i--) send_bit(b[i], (i == 0 && latchk) ? 1 : 0);
`endif
    endtask

    task automatic resync();
        syn = 1'b0;
        repeat (4) @(negedge clk);
        syn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: pops and compares on every accepted handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%0h required=none", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("frame_start", frame_start, e.fs);
                    chk("out_perr", out_perr, e.pe);
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_out_perr", out_perr, 0);
        chk("rst_in_frame", in_frame, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // No lock: sync word and data are ignored.
        send_sync(0);
        send_byte(8'h3C, 1'b0, 1'b1, 0, 0);
        chk("idle_in_frame", in_frame, 0);
        chk("idle_out_valid", out_valid, 0);

        // Locked: full frame, then return to HUNT and a fresh frame.
        syn = 1'b1;
        repeat (4) @(negedge clk);
        send_sync(1);
        send_byte(8'h3C, 1'b0, 1'b1, 1, 1);
        send_byte(8'h81, 1'b0, 1'b0, 1, 1);
        for (int i = 2; i < 15; i++) send_byte(8'(8'h10 + i), 1'b1, 1'b0, 1, 0);
        send_byte(8'h00, 1'b0, 1'b0, 1, 1);
        chk("frame_end_hunt", in_frame, 0);
        send_sync(1);
        send_byte(8'h55, 1'b0, 1'b1, 1, 1);

        // Backpressure: second byte dropped, overflow set then cleared.
        resync();
        out_ready = 1'b0;
        send_sync(0);
        send_byte(8'h5A, 1'b0, 1'b1, 1, 0);
        send_byte(8'h6B, 1'b1, 1'b0, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_hold_valid", out_valid, 1);
        chk("ovf_hold_data", out_data, 8'h5A);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // syn drop mid-byte with a byte pending.
        out_ready = 1'b0;
        send_byte(8'h77, 1'b0, 1'b0, 1, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        syn = 1'b0;
        @(negedge clk);
        chk("abort_in_frame", in_frame, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
        chk("abort_pending_valid", out_valid, 1);
        chk("abort_pending_data", out_data, 8'h77);
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_partial", out_valid, 0);

        // rec_clk stops in DATA: timeout to IDLE, then HUNT again.
        syn = 1'b1;
        repeat (4) @(negedge clk);
        send_sync(0);
        send_byte(8'h42, 1'b0, 1'b1, 1, 0);
        chk("tmo_in_frame", in_frame, 1);
        n = 0;
        while (in_frame && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_lat", n, 251);
        send_sync(1);
        send_byte(8'hC3, 1'b0, 1'b1, 1, 1);

        // Parity bit handling (out_perr stays 0 without the parity build).
        resync();
        send_sync(0);
        send_byte(8'h3C, 1'b1, 1'b1, 1, 0);
        send_byte(8'h3C, 1'b0, 1'b0, 1, 0);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
